// File: rtl/cmplx_mult_acc.sv
// -----------------------------------------------------------------------------
// cmplx_mult_acc
//
// Pipelined complex multiplier with optional conjugation of operand B, followed
// by an integrate-and-dump accumulator that sums ACC_LEN products per output.
// Used in the CFO estimation path to form sum(x[n] * conj(x[n+D])). With
// ACC_LEN = 1 it behaves as a plain streaming complex multiplier that delivers
// one result per cycle.
//
// Pipeline (one register per step, all steps stall together):
//   stage A : sign-extended operands (conj applied to im_b here)
//   stage B : the four full-precision partial products
//   stage C : real / imaginary product sums
//   output  : accumulator update and dump into the output register
// An operand set accepted at edge k whose product completes a block shows up
// as out_valid = 1 after edge k+3.
//
// Parameters:
//   IN_W    signed width of each input component
//   OUT_W   signed width of each output component
//   ACC_LEN number of products summed per output (>= 1)
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   in_valid  operand set valid
//   in_ready  block can accept operands this cycle (low only while stalled)
//   re_a/im_a operand A, signed
//   re_b/im_b operand B, signed
//   conj_b    1: multiply by conj(B); sampled with the operands
//   out_valid result valid
//   out_ready downstream accepts the result
//   out_re/im accumulated result, signed
//
// Compile-time option:
//   CMPLX_MULT_SAT_EN  when defined, an accumulator value that does not fit in
//                      OUT_W bits clamps to the nearest bound per component.
//                      When undefined, the low OUT_W bits are taken (wrap) and
//                      no clamp logic exists.
// -----------------------------------------------------------------------------
module cmplx_mult_acc #(
    parameter int IN_W    = 9,
    parameter int OUT_W   = 24,
    parameter int ACC_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  re_a,
    input  logic [IN_W-1:0]  im_a,
    input  logic [IN_W-1:0]  re_b,
    input  logic [IN_W-1:0]  im_b,
    input  logic             conj_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_re,
    output logic [OUT_W-1:0] out_im
);

    // Extended operand width: one extra bit so that negating the most
    // negative im_b value stays representable.
    localparam int EW      = IN_W + 1;
    // Full-precision product width.
    localparam int PW      = 2 * EW;
    localparam int LOG_LEN = $clog2(ACC_LEN);
    localparam int ACC_W   = PW + LOG_LEN;
    localparam int CNT_W   = (ACC_LEN > 1) ? LOG_LEN : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    // ------------------------------------------------------------------
    // Handshake: the whole pipeline freezes while a result waits for the
    // consumer, so accepting input is allowed exactly when not frozen.
    // ------------------------------------------------------------------
    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // ------------------------------------------------------------------
    // Stage A: sign extension and optional conjugation
    // ------------------------------------------------------------------
    logic signed [EW-1:0] ar_next, ai_next, br_next, bi_ext, bi_next;

    always_comb begin
        ar_next = EW'($signed(re_a));
        ai_next = EW'($signed(im_a));
        br_next = EW'($signed(re_b));
        bi_ext  = EW'($signed(im_b));
        bi_next = conj_b ? -bi_ext : bi_ext;
    end

    logic                 a_valid_reg;
    logic signed [EW-1:0] ar_reg, ai_reg, br_reg, bi_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_reg <= 1'b0;
            ar_reg      <= '0;
            ai_reg      <= '0;
            br_reg      <= '0;
            bi_reg      <= '0;
        end else if (!stall) begin
            // in_ready is high here, so in_valid alone marks a transfer.
            a_valid_reg <= in_valid;
            ar_reg      <= ar_next;
            ai_reg      <= ai_next;
            br_reg      <= br_next;
            bi_reg      <= bi_next;
        end
    end

    // ------------------------------------------------------------------
    // Stage B: four partial products
    //   index 0: ar*br   1: ai*bi   2: ar*bi   3: ai*br
    // ------------------------------------------------------------------
    logic signed [EW-1:0] mul_x [4];
    logic signed [EW-1:0] mul_y [4];
    logic signed [PW-1:0] prod_next [4];
    logic signed [PW-1:0] prod_reg  [4];
    logic                 b_valid_reg;

    assign mul_x = '{ar_reg, ai_reg, ar_reg, ai_reg};
    assign mul_y = '{br_reg, bi_reg, bi_reg, br_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_prod
            assign prod_next[gi] = PW'(mul_x[gi]) * PW'(mul_y[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid_reg <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                prod_reg[i] <= '0;
            end
        end else if (!stall) begin
            b_valid_reg <= a_valid_reg;
            for (int i = 0; i < 4; i++) begin
                prod_reg[i] <= prod_next[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage C: complex product. Each operand magnitude is at most 2^(IN_W-1),
    // so each product is at most 2^(2*IN_W-2) and the sum of two still fits
    // comfortably in PW bits.
    //   index 0: real part   1: imaginary part
    // ------------------------------------------------------------------
    logic signed [PW-1:0] p_next [2];
    logic signed [PW-1:0] p_reg  [2];
    logic                 c_valid_reg;

    assign p_next[0] = prod_reg[0] - prod_reg[1];
    assign p_next[1] = prod_reg[2] + prod_reg[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_valid_reg <= 1'b0;
            p_reg[0]    <= '0;
            p_reg[1]    <= '0;
        end else if (!stall) begin
            c_valid_reg <= b_valid_reg;
            p_reg[0]    <= p_next[0];
            p_reg[1]    <= p_next[1];
        end
    end

    // ------------------------------------------------------------------
    // Accumulator sum and output conversion
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] acc_reg  [2];
    logic signed [ACC_W-1:0] sum_next [2];
    logic        [OUT_W-1:0] conv     [2];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_conv
            assign sum_next[gi] = acc_reg[gi] + ACC_W'(p_reg[gi]);

            if (OUT_W >= ACC_W) begin : g_ext
                // Output is at least as wide as the accumulator: sign-extend.
                assign conv[gi] = OUT_W'(sum_next[gi]);
            end else begin : g_narrow
`ifdef CMPLX_MULT_SAT_EN
                // The value fits in OUT_W bits exactly when every bit from the
                // output sign bit upward is identical; otherwise clamp toward
                // the side indicated by the accumulator sign.
                logic [ACC_W-OUT_W:0] top_bits;
                logic                 fits;
                assign top_bits = sum_next[gi][ACC_W-1:OUT_W-1];
                assign fits     = (&top_bits) | ~(|top_bits);
                assign conv[gi] = fits ? sum_next[gi][OUT_W-1:0]
                                : (top_bits[ACC_W-OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                         : {1'b0, {(OUT_W-1){1'b1}}});
`else
                // Two's-complement wrap: keep the low OUT_W bits.
                assign conv[gi] = sum_next[gi][OUT_W-1:0];
`endif
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Integrate-and-dump. Only valid stage-C products advance the counter
    // or touch the accumulator; bubbles pass through without effect.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_reg;
    logic             out_valid_reg;
    logic [OUT_W-1:0] out_reg [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                acc_reg[i] <= '0;
                out_reg[i] <= '0;
            end
        end else if (!stall) begin
            // Not stalled means any held result is being consumed now, so
            // out_valid only stays high if a new result loads on this edge.
            out_valid_reg <= 1'b0;
            if (c_valid_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    out_valid_reg <= 1'b1;
                    cnt_reg       <= '0;
                    for (int i = 0; i < 2; i++) begin
                        out_reg[i] <= conv[i];
                        acc_reg[i] <= '0;
                    end
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    for (int i = 0; i < 2; i++) begin
                        acc_reg[i] <= sum_next[i];
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_re    = out_reg[0];
    assign out_im    = out_reg[1];

endmodule

// File: tb/tb_cmplx_mult_acc.sv
// -----------------------------------------------------------------------------
// tb_cmplx_mult_acc
//
// Directed bench for cmplx_mult_acc. Three instances are exercised:
//   u_len1  : IN_W=9, OUT_W=24, ACC_LEN=1 (streaming multiplier, backpressure)
//   u_narrow: IN_W=9, OUT_W=16, ACC_LEN=1 (output wrap / clamp)
//   u_len4  : IN_W=9, OUT_W=24, ACC_LEN=4 (integrate-and-dump, reset)
// Operands are shared; in_valid is steered to the instance chosen by sel.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_cmplx_mult_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic [8:0] re_a, im_a, re_b, im_b;
    logic       conj_b;
    int         sel;

    logic iv0, iv1, iv2;
    logic ord0;
    logic ir0, ir1, ir2;
    logic ov0, ov1, ov2;
    logic [23:0] ore0, oim0, ore2, oim2;
    logic [15:0] ore1, oim1;

    always_comb begin
        iv0 = in_valid && (sel == 0);
        iv1 = in_valid && (sel == 1);
        iv2 = in_valid && (sel == 2);
    end

    cmplx_mult_acc #(.IN_W(9), .OUT_W(24), .ACC_LEN(1)) u_len1 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
        .re_a(re_a), .im_a(im_a), .re_b(re_b), .im_b(im_b), .conj_b(conj_b),
        .out_valid(ov0), .out_ready(ord0), .out_re(ore0), .out_im(oim0)
    );

    cmplx_mult_acc #(.IN_W(9), .OUT_W(16), .ACC_LEN(1)) u_narrow (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .re_a(re_a), .im_a(im_a), .re_b(re_b), .im_b(im_b), .conj_b(conj_b),
        .out_valid(ov1), .out_ready(1'b1), .out_re(ore1), .out_im(oim1)
    );

    cmplx_mult_acc #(.IN_W(9), .OUT_W(24), .ACC_LEN(4)) u_len4 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .re_a(re_a), .im_a(im_a), .re_b(re_b), .im_b(im_b), .conj_b(conj_b),
        .out_valid(ov2), .out_ready(1'b1), .out_re(ore2), .out_im(oim2)
    );

    // Selected-instance view of the outputs
    logic   o_valid, o_rdy, o_inr;
    longint o_re, o_im;

    always_comb begin
        o_valid = ov0;
        o_rdy   = ord0;
        o_inr   = ir0;
        o_re    = longint'($signed(ore0));
        o_im    = longint'($signed(oim0));
        case (sel)
            1: begin
                o_valid = ov1;
                o_rdy   = 1'b1;
                o_inr   = ir1;
                o_re    = longint'($signed(ore1));
                o_im    = longint'($signed(oim1));
            end
            2: begin
                o_valid = ov2;
                o_rdy   = 1'b1;
                o_inr   = ir2;
                o_re    = longint'($signed(ore2));
                o_im    = longint'($signed(oim2));
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got %0d ok", tag, got);
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Collect every result transferred by the selected instance
    longint q_re[$];
    longint q_im[$];

    always @(negedge clk) begin
        if (!rst && o_valid && o_rdy) begin
            q_re.push_back(o_re);
            q_im.push_back(o_im);
            $display("result sel=%0d re=%0d im=%0d", sel, o_re, o_im);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; each starts and ends 1 ns after a rising edge
    // ------------------------------------------------------------------
    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input logic cj);
        re_a     = 9'(ar);
        im_a     = 9'(ai);
        re_b     = 9'(br);
        im_b     = 9'(bi);
        conj_b   = cj;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic one_shot(input string tag, input int ar, input int ai,
                            input int br, input int bi, input logic cj,
                            input longint exp_re, input longint exp_im);
        q_re.delete();
        q_im.delete();
        send(ar, ai, br, bi, cj);
        idle(6);
        check({tag, "_cnt"}, q_re.size(), 1);
        if (q_re.size() > 0) begin
            check({tag, "_re"}, q_re[0], exp_re);
            check({tag, "_im"}, q_im[0], exp_im);
        end
    endtask

    int     lat;
    int     idx;
    int     guard;
    longint sat_im;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        sel      = 0;
        ord0     = 1'b1;
        re_a     = '0;
        im_a     = '0;
        re_b     = '0;
        im_b     = '0;
        conj_b   = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ov0", ov0, 0);
        check("rst_ir0", ir0, 1);
        check("rst_re0", ore0, 0);
        check("rst_im0", oim0, 0);
        check("rst_ov2", ov2, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // conj_b=0: (3+4j)(2-1j) = 10+5j, with latency
        q_re.delete();
        q_im.delete();
        send(3, 4, 2, -1, 1'b0);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (ov0) break;
        end
        // first negedge after the accepting edge k counts as 1, so valid
        // after edge k+3 is seen on count 4
        check("lat", lat, 4);
        check("mul_re", o_re, 10);
        check("mul_im", o_im, 5);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("drop_ov", ov0, 0);
        @(posedge clk);
        #1;

        // conj_b=1: (3+4j)conj(2+1j) = 10+5j
        one_shot("conj", 3, 4, 2, 1, 1'b1, 10, 5);
        // (1+0j)conj(0-256j) = 0+256j
        one_shot("neg", 1, 0, 0, -256, 1'b1, 0, 256);

        // Narrow output: (-256-256j)^2 = 0+131072j
        sel = 1;
`ifdef CMPLX_MULT_SAT_EN
        sat_im = 32767;
`else
        sat_im = 0;
`endif
        one_shot("narrow", -256, -256, -256, -256, 1'b0, 0, sat_im);

        // ACC_LEN=4: four (1+j)conj(1+j)=2 with idle gaps -> 8+0j
        sel = 2;
        q_re.delete();
        q_im.delete();
        for (int i = 0; i < 4; i++) begin
            send(1, 1, 1, 1, 1'b1);
            idle(2);
        end
        idle(4);
        check("acc4_cnt", q_re.size(), 1);
        if (q_re.size() > 0) begin
            check("acc4_re", q_re[0], 8);
            check("acc4_im", q_im[0], 0);
        end
        // Next block restarts from zero: four (2)(1+j) -> 8+8j
        q_re.delete();
        q_im.delete();
        for (int i = 0; i < 4; i++) begin
            send(2, 0, 1, 1, 1'b0);
        end
        idle(5);
        check("acc4b_cnt", q_re.size(), 1);
        if (q_re.size() > 0) begin
            check("acc4b_re", q_re[0], 8);
            check("acc4b_im", q_im[0], 8);
        end

        // Backpressure on ACC_LEN=1: sample i is (i+1)(1+2j)
        sel = 0;
        q_re.delete();
        q_im.delete();
        idx   = 0;
        guard = 0;
        fork
            begin
                while (idx < 10 && guard < 100) begin
                    re_a     = 9'(idx + 1);
                    im_a     = '0;
                    re_b     = 9'd1;
                    im_b     = 9'd2;
                    conj_b   = 1'b0;
                    in_valid = 1'b1;
                    @(negedge clk);
                    if (o_inr) idx++;
                    @(posedge clk);
                    #1;
                    guard++;
                end
                in_valid = 1'b0;
            end
            begin
                // Samples 0 and 1 drain before the stall; sample 2 (3+6j)
                // sits in the output register while out_ready is low.
                repeat (6) @(posedge clk);
                #1;
                ord0 = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("bp_inr", o_inr, 0);
                    check("bp_hold_re", o_re, 3);
                    check("bp_hold_im", o_im, 6);
                    @(posedge clk);
                    #1;
                end
                ord0 = 1'b1;
            end
        join
        check("bp_sent", idx, 10);
        idle(8);
        check("bp_cnt", q_re.size(), 10);
        for (int i = 0; i < 10 && i < q_re.size(); i++) begin
            check($sformatf("bp_re%0d", i), q_re[i], i + 1);
            check($sformatf("bp_im%0d", i), q_im[i], 2 * (i + 1));
        end

        // Asynchronous reset mid-block on ACC_LEN=4 (output still holds 8+8j)
        sel = 2;
        send(1, 1, 1, 1, 1'b1);
        send(1, 1, 1, 1, 1'b1);
        idle(1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ov", ov2, 0);
        check("arst_re", ore2, 0);
        check("arst_im", oim2, 0);
        check("arst_ir", ir2, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        q_re.delete();
        q_im.delete();
        for (int i = 0; i < 4; i++) begin
            send(1, 0, 1, 0, 1'b0);
        end
        idle(5);
        check("post_cnt", q_re.size(), 1);
        if (q_re.size() > 0) begin
            check("post_re", q_re[0], 4);
            check("post_im", q_im[0], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/cmplx_mult_acc.md
Name: cmplx_mult_acc

Overview:
- Pipelined, parametrised complex multiplier with optional conjugation of operand B and an integrate-and-dump accumulator over ACC_LEN products.
- Sits in the CFO estimation datapath. It forms the delayed autocorrelation sum(x[n]·conj(x[n+D])) ahead of the phase/angle stage.
- Can also serve as a plain streaming complex multiplier when ACC_LEN=1.
- Uses a valid/ready handshake on both sides with full-pipeline stall.

Parameters:
- IN_W, 9, signed width of each input component.
- OUT_W, 24, signed width of each output component.
- ACC_LEN, 16, number of products summed per output; must be ≥1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands this cycle.
- re_a, im_a  input  IN_W  operand A, signed.
- re_b, im_b  input  IN_W  operand B, signed.
- conj_b  input  1  1: use conj(B); sampled with the operands.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_re, out_im  output  OUT_W  accumulated result, signed.

Behaviour:
- Reset is asynchronous and active-high. It clears all stage valids, the accumulator, the sample counter, out_valid, out_re and out_im to 0. in_ready is 1 immediately after reset.
- stall = out_valid & ~out_ready. in_ready = ~stall. When stall is high, every stage register, valid bit and the counter hold.
- Transfer occurs on in_valid & in_ready.
- Stage A: register operands sign-extended to IN_W+1. When conj_b=1, im_b is negated in IN_W+1 bits, so -2^(IN_W-1) negates without overflow.
- Stage B: register the four products ar·br, ai·bi, ar·bi, ai·br, each full precision (2·IN_W+2 bits).
- Stage C: p_re = ar·br − ai·bi and p_im = ar·bi + ai·br. The sum adds into a signed accumulator of width 2·IN_W+2+clog2(ACC_LEN). No internal truncation.
- Counter: cnt goes 0..ACC_LEN-1 and advances only on a valid stage-C product.
  - On cnt==ACC_LEN-1, acc+p loads the output register, out_valid is set, the accumulator restarts at 0, and cnt wraps to 0.
  - Otherwise acc ← acc+p.
- Latency: the last operand of a block accepted at edge k gives out_valid=1 after edge k+3, provided there is no stall. With ACC_LEN=1 the block delivers one result per cycle at full throughput.
- Bubbles (in_valid=0) propagate as invalid stages. They do not advance cnt and do not alter acc.
- out_valid falls on out_valid & out_ready unless a new result loads on the same edge. In that case out_valid stays 1 with new data.
- Output conversion: the accumulator's low OUT_W bits are taken, sign preserved (wrap), unless the optional feature is compiled in. If OUT_W ≥ accumulator width, the value is sign-extended.
- conj_b may change per sample. It travels with its operands through the pipeline.

Optional Feature:
- Macro: CMPLX_MULT_SAT_EN.
- Defined: an accumulator value outside [−2^(OUT_W−1), 2^(OUT_W−1)−1] clamps to the nearest bound, independently per component.
- Undefined: two's-complement wrap, meaning the low OUT_W bits only, with no saturation logic synthesised.

Test Plan:
- ACC_LEN=1, IN_W=9, OUT_W=24, conj_b=0: A=3+4j, B=2−1j -> out 10+5j, out_valid 3 cycles after accept.
- ACC_LEN=1, conj_b=1: A=3+4j, B=2+1j -> out 10+5j. A=1+0j, B=0+(−256)j -> out 0+256j (no overflow on negation).
- ACC_LEN=1, OUT_W=16: A=B=−256−256j -> exact 0+131072j.
  - With CMPLX_MULT_SAT_EN: out 0+32767j.
  - Without: out 0+0j.
- ACC_LEN=4: four accepts of A=1+1j, B=1+1j with conj_b=1, interleaved with 2 idle cycles -> exactly one out_valid, out 8+0j. The next block starts from zero.
- Backpressure, ACC_LEN=1: stream 10 samples with out_ready held low for 5 cycles mid-stream -> in_ready=0 while stall; output held stable; all 10 results delivered in order, none lost or duplicated.
- Assert rst after 2 of 4 samples in an ACC_LEN=4 block -> all outputs 0 asynchronously. The next 4 samples of 1·1 produce out 4+0j.
